// File: rtl/iddmm_operand_loader.sv
// Operand loader for the IDDMM multiplier.
// Streams the x, y and m operands (least-significant word first) into three
// word buffers, raises task_req for one cycle once all of them are complete,
// then serves registered random-access reads to the multiply controller until
// task_end releases the buffers for the next operation.
module iddmm_operand_loader #(
   parameter int K      = 128,
   parameter int N      = 32,
   parameter int ADDR_W = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [K-1:0]      in_data,
   output logic              task_req,
   input  logic              task_end,
   input  logic [ADDR_W:0]   rd_data_addr_i,
   input  logic [ADDR_W:0]   rd_data_addr_j,
   output logic [K-1:0]      x_word,
   output logic [K-1:0]      y_word,
   output logic [K-1:0]      m_word,
   output logic              busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_X,
      ST_LOAD_Y,
      ST_LOAD_M,
      ST_REQ,
      ST_RUN
   } state_e;

   localparam logic [1:0] SEL_X = 2'd0;
   localparam logic [1:0] SEL_Y = 2'd1;
   localparam logic [1:0] SEL_M = 2'd2;

   state_e              state_q;
   logic [ADDR_W-1:0]   w_cnt_q;
   logic [1:0]          sel_q;
   logic                in_ready_q;
   logic                task_req_q;
   logic                busy_q;
   logic [K-1:0]        x_word_q;
   logic [K-1:0]        y_word_q;
   logic [K-1:0]        m_word_q;

   logic [K-1:0]        x_mem [N];
   logic [K-1:0]        y_mem [N];
   logic [K-1:0]        m_mem [N];

   logic                xfer;
   logic                last_word;
   logic                rd_i_ok;
   logic                rd_j_ok;

   assign xfer      = in_valid && in_ready_q;
   assign last_word = (w_cnt_q == ADDR_W'(N - 1));

   // Indices >= N (including the controller's extra j = N) read as zero.
   assign rd_i_ok = (rd_data_addr_i < (ADDR_W + 1)'(N));
   assign rd_j_ok = (rd_data_addr_j < (ADDR_W + 1)'(N));

   // Load / request / run sequencer; outputs are registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         w_cnt_q    <= '0;
         sel_q      <= SEL_X;
         in_ready_q <= 1'b1;
         task_req_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // branch below sees the pre-edge values of all registers.
         task_req_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_LOAD_X, ST_LOAD_Y, ST_LOAD_M: begin
               if (xfer) begin
                  busy_q <= 1'b1;
                  if (last_word) begin
                     w_cnt_q <= '0;
                     sel_q   <= sel_q + 2'd1;
                     case (sel_q)
                        SEL_X:   state_q <= ST_LOAD_Y;
                        SEL_Y:   state_q <= ST_LOAD_M;
                        default: begin
                           state_q    <= ST_REQ;
                           task_req_q <= 1'b1;
                           in_ready_q <= 1'b0;
                        end
                     endcase
                  end else begin
                     w_cnt_q <= w_cnt_q + 1'b1;
                     if (state_q == ST_IDLE) begin
                        state_q <= ST_LOAD_X;
                     end
                  end
               end
            end
            ST_REQ: begin
               state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (task_end) begin
                  state_q    <= ST_IDLE;
                  w_cnt_q    <= '0;
                  sel_q      <= SEL_X;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               w_cnt_q    <= '0;
               sel_q      <= SEL_X;
               in_ready_q <= 1'b1;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   // Operand buffer writes, steered by the operand select and word counter.
   // NOTE: the buffers have no reset; contents survive reset and task_end and
   // are simply overwritten by the next load, which lets them map onto RAM.
   always_ff @(posedge clk) begin
      if (xfer) begin
         case (sel_q)
            SEL_X:   x_mem[w_cnt_q] <= in_data;
            SEL_Y:   y_mem[w_cnt_q] <= in_data;
            SEL_M:   m_mem[w_cnt_q] <= in_data;
            default: ;
         endcase
      end
   end

   // Registered read ports; a same-cycle write to the read location yields old data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_word_q <= '0;
         y_word_q <= '0;
         m_word_q <= '0;
      end else begin
         x_word_q <= rd_i_ok ? x_mem[rd_data_addr_i[ADDR_W-1:0]] : '0;
         y_word_q <= rd_j_ok ? y_mem[rd_data_addr_j[ADDR_W-1:0]] : '0;
         m_word_q <= rd_j_ok ? m_mem[rd_data_addr_j[ADDR_W-1:0]] : '0;
      end
   end

   assign in_ready = in_ready_q;
   assign task_req = task_req_q;
   assign busy     = busy_q;
   assign x_word   = x_word_q;
   assign y_word   = y_word_q;
   assign m_word   = m_word_q;

endmodule

// File: tb/tb_iddmm_operand_loader.sv
// Self-checking bench for iddmm_operand_loader (N=4, K=8).
// The reference model treats the 3*N-word stream as a flat sequence: word k
// belongs to operand k/N at index k%N. Buffers are modelled as plain arrays.
module tb_iddmm_operand_loader;

   localparam int K  = 8;
   localparam int N  = 4;
   localparam int AW = 2;
   localparam int NW = 3 * N;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [K-1:0]  in_data;
   logic          task_req;
   logic          task_end;
   logic [AW:0]   rd_data_addr_i;
   logic [AW:0]   rd_data_addr_j;
   logic [K-1:0]  x_word;
   logic [K-1:0]  y_word;
   logic [K-1:0]  m_word;
   logic          busy;

   iddmm_operand_loader #(.K(K), .N(N), .ADDR_W(AW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .task_req       (task_req),
      .task_end       (task_end),
      .rd_data_addr_i (rd_data_addr_i),
      .rd_data_addr_j (rd_data_addr_j),
      .x_word         (x_word),
      .y_word         (y_word),
      .m_word         (m_word),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks   = 0;
   int n_pass     = 0;
   int req_pulses = 0;

   // Reference model of the three operand buffers plus "written yet" flags.
   logic [K-1:0] mx [N];
   logic [K-1:0] my [N];
   logic [K-1:0] mm [N];
   bit           vx [N];
   bit           vy [N];
   bit           vm [N];
   logic [K-1:0] words [NW];

   // Count every cycle in which task_req is high.
   always @(posedge clk) begin
      if (task_req === 1'b1) req_pulses++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gen_random_words();
      for (int k = 0; k < NW; k++) words[k] = K'($urandom_range(0, 255));
   endtask

   // Stream words[lo..hi-1]; optional random idle cycles between transfers.
   // Each transfer also reads the location being written and expects the old value.
   task automatic load_range(input int lo, input int hi, input bit gaps);
      int           op;
      int           idx;
      int           budget;
      bit           done;
      bit           rdy;
      bit           old_ok;
      logic [K-1:0] old_val;
      logic [K-1:0] obs;
      for (int k = lo; k < hi; k++) begin
         op     = k / N;
         idx    = k % N;
         done   = 1'b0;
         budget = 0;
         while (!done) begin
            if (budget > 40) begin
               n_checks++;
               $display("FAIL load_timeout word=%0d in_ready=%b never accepted", k, in_ready);
               done = 1'b1;
            end else begin
               budget++;
               if (gaps && $urandom_range(0, 2) == 0) begin
                  in_valid = 1'b0;
                  tick();
               end else begin
                  in_valid = 1'b1;
                  in_data  = words[k];
                  rdy      = in_ready;
                  if (op == 0) begin
                     rd_data_addr_i = 3'(idx);
                     old_val = mx[idx];
                     old_ok  = vx[idx];
                  end else if (op == 1) begin
                     rd_data_addr_j = 3'(idx);
                     old_val = my[idx];
                     old_ok  = vy[idx];
                  end else begin
                     rd_data_addr_j = 3'(idx);
                     old_val = mm[idx];
                     old_ok  = vm[idx];
                  end
                  tick();
                  if (rdy) begin
                     done = 1'b1;
                     obs  = (op == 0) ? x_word : (op == 1) ? y_word : m_word;
                     if (old_ok) begin
                        n_checks++;
                        if (obs !== old_val)
                           $display("FAIL read_during_write op=%0d idx=%0d got=%h exp=%h", op, idx, obs, old_val);
                        else n_pass++;
                     end
                     if (op == 0) begin mx[idx] = words[k]; vx[idx] = 1'b1; end
                     else if (op == 1) begin my[idx] = words[k]; vy[idx] = 1'b1; end
                     else begin mm[idx] = words[k]; vm[idx] = 1'b1; end
                  end
               end
            end
         end
      end
      in_valid = 1'b0;
   endtask

   // Called right after the final transfer: task_req must be high now, for one
   // cycle only, and the loader must refuse words for hold cycles of RUN.
   task automatic check_req(input int p0, input int hold);
      n_checks++;
      if (task_req !== 1'b1) $display("FAIL req_after_load task_req=%b exp=1", task_req);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1)
         $display("FAIL req_state in_ready=%b busy=%b exp in_ready=0 busy=1", in_ready, busy);
      else n_pass++;
      tick();
      n_checks++;
      if (task_req !== 1'b0 || (req_pulses - p0) != 1)
         $display("FAIL req_single task_req=%b pulses=%0d exp task_req=0 pulses=1", task_req, req_pulses - p0);
      else n_pass++;
      for (int c = 0; c < hold; c++) begin
         in_valid = 1'b1;
         in_data  = K'($urandom_range(0, 255));
         n_checks++;
         if (in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL run_hold cycle=%0d in_ready=%b busy=%b exp 0/1", c, in_ready, busy);
         else n_pass++;
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic end_task(input int p0);
      task_end = 1'b1;
      tick();
      task_end = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || task_req !== 1'b0)
         $display("FAIL task_end_idle busy=%b in_ready=%b task_req=%b exp 0/1/0", busy, in_ready, task_req);
      else n_pass++;
      n_checks++;
      if ((req_pulses - p0) != 1) $display("FAIL req_total pulses=%0d exp=1", req_pulses - p0);
      else n_pass++;
   endtask

   // Sweep addresses 0..7; indices >= N must read zero.
   task automatic verify_reads();
      logic [K-1:0] ex;
      logic [K-1:0] ey;
      logic [K-1:0] em;
      for (int a = 0; a < 8; a++) begin
         rd_data_addr_i = 3'(a);
         rd_data_addr_j = 3'(7 - a);
         ex = (a < N) ? mx[a] : '0;
         ey = ((7 - a) < N) ? my[7 - a] : '0;
         em = ((7 - a) < N) ? mm[7 - a] : '0;
         tick();
         n_checks++;
         if (x_word !== ex || y_word !== ey || m_word !== em)
            $display("FAIL read i=%0d j=%0d got x=%h y=%h m=%h exp x=%h y=%h m=%h",
                     a, 7 - a, x_word, y_word, m_word, ex, ey, em);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; task_end = 1'b0;
      rd_data_addr_i = '0; rd_data_addr_j = '0;
      #12;
      n_checks++;
      if (busy !== 1'b0 || task_req !== 1'b0 || in_ready !== 1'b1 ||
          x_word !== '0 || y_word !== '0 || m_word !== '0)
         $display("FAIL reset_outputs busy=%b req=%b rdy=%b x=%h y=%h m=%h exp 0/0/1/00/00/00",
                  busy, task_req, in_ready, x_word, y_word, m_word);
      else n_pass++;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      int p0;
      for (int k = 0; k < NW; k++) words[k] = K'(k + 1);
      p0 = req_pulses;
      load_range(0, NW, 1'b0);
      check_req(p0, 3);
      verify_reads();
      rd_data_addr_i = 3'd2;
      rd_data_addr_j = 3'd4;
      tick();
      n_checks++;
      if (x_word !== 8'h03 || y_word !== 8'h00 || m_word !== 8'h00)
         $display("FAIL run_read_oob x=%h y=%h m=%h exp 03/00/00", x_word, y_word, m_word);
      else n_pass++;
      end_task(p0);
   endtask

   task automatic test_task_end_ignored();
      int p0;
      gen_random_words();
      p0 = req_pulses;
      load_range(0, N + 2, 1'b0);
      task_end = 1'b1;
      tick();
      task_end = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1)
         $display("FAIL task_end_in_load busy=%b in_ready=%b exp 1/1", busy, in_ready);
      else n_pass++;
      load_range(N + 2, NW, 1'b0);
      check_req(p0, 2);
      end_task(p0);
      verify_reads();
   endtask

   task automatic test_gaps();
      int p0;
      gen_random_words();
      p0 = req_pulses;
      load_range(0, NW, 1'b1);
      check_req(p0, 6);
      verify_reads();
      end_task(p0);
   endtask

   task automatic test_reset_mid_load();
      int p0;
      gen_random_words();
      load_range(0, 6, 1'b0);
      rst_n = 1'b0;
      #2;
      n_checks++;
      if (busy !== 1'b0 || task_req !== 1'b0 || in_ready !== 1'b1 ||
          x_word !== '0 || y_word !== '0 || m_word !== '0)
         $display("FAIL reset_mid busy=%b req=%b rdy=%b x=%h y=%h m=%h exp 0/0/1/00/00/00",
                  busy, task_req, in_ready, x_word, y_word, m_word);
      else n_pass++;
      tick();
      rst_n = 1'b1;
      tick();
      gen_random_words();
      p0 = req_pulses;
      load_range(0, NW, 1'b0);
      check_req(p0, 1);
      verify_reads();
      end_task(p0);
   endtask

   task automatic test_two_tasks();
      int p0;
      logic [K-1:0] first [NW];
      gen_random_words();
      for (int k = 0; k < NW; k++) first[k] = words[k];
      p0 = req_pulses;
      load_range(0, NW, 1'b1);
      check_req(p0, 1);
      end_task(p0);
      for (int k = 0; k < NW; k++) words[k] = first[k] ^ 8'h5A;
      p0 = req_pulses;
      load_range(0, NW, 1'b0);
      check_req(p0, 1);
      verify_reads();
      end_task(p0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin vx[i] = 1'b0; vy[i] = 1'b0; vm[i] = 1'b0; end
      test_reset();
      test_back_to_back();
      test_task_end_ignored();
      test_gaps();
      test_reset_mid_load();
      test_two_tasks();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
